// File: rtl/ltc2308_pkg.sv
// rtl/ltc2308_pkg.sv - shared types, frame geometry and config-word builder for the LTC2308 master
package ltc2308_pkg;

    localparam int FRAME_BITS  = 12;
    localparam int RESULT_BITS = 12;

    // Config word bit positions within the 12-bit SDI frame (MSB sent first)
    localparam int CFG_SD  = 11;
    localparam int CFG_OS  = 10;
    localparam int CFG_S1  = 9;
    localparam int CFG_S0  = 8;
    localparam int CFG_UNI = 7;
    localparam int CFG_SLP = 6;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PULSE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_SHIFT = 2'd3
    } state_e;

    // Single-ended only; the LTC2308 channel address maps ch[0] to O/S and ch[2:1] to S1/S0.
    function automatic logic [FRAME_BITS-1:0] build_frame(input logic [2:0] ch, input logic uni);
        logic [FRAME_BITS-1:0] f;
        f          = '0;
        f[CFG_SD]  = 1'b1;
        f[CFG_OS]  = ch[0];
        f[CFG_S1]  = ch[2];
        f[CFG_S0]  = ch[1];
        f[CFG_UNI] = uni;
        f[CFG_SLP] = 1'b0;
        return f;
    endfunction

endpackage

// File: rtl/ltc2308_adc_master_if.sv
// rtl/ltc2308_adc_master_if.sv - host request/result bundle for the LTC2308 master
interface ltc2308_adc_master_if;
    import ltc2308_pkg::*;

    logic                   start;
    logic [2:0]             channel;
    logic                   uni;
    logic                   busy;
    logic                   valid;
    logic [RESULT_BITS-1:0] data;
    logic [2:0]             data_channel;

    modport master (
        output start, channel, uni,
        input  busy, valid, data, data_channel
    );

    modport slave (
        input  start, channel, uni,
        output busy, valid, data, data_channel
    );

endinterface

// File: rtl/ltc2308_shifter.sv
// rtl/ltc2308_shifter.sv - SCK divider plus 12-bit SDI/SDO shift pair
module ltc2308_shifter
    import ltc2308_pkg::*;
#(
    parameter int CLK_DIV = 2
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   load,
    input  logic [FRAME_BITS-1:0]  frame_in,
    input  logic                   sdo,
    output logic                   sck,
    output logic                   sdi,
    output logic                   done,
    output logic [RESULT_BITS-1:0] data_out
);

    localparam int             DW       = $clog2(CLK_DIV + 1);
    localparam logic [DW-1:0]  DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [3:0]     LAST_BIT = 4'(FRAME_BITS - 1);

    logic                   active_q, active_d;
    logic [DW-1:0]          div_q, div_d;
    logic                   sck_q, sck_d;
    logic                   sdi_q, sdi_d;
    logic [3:0]             bit_q, bit_d;
    logic [FRAME_BITS-2:0]  tx_q, tx_d;
    logic [RESULT_BITS-1:0] rx_q, rx_d;
    logic                   tick;

    assign tick     = active_q && (div_q == DIV_LAST);
    // Completion is the falling edge that closes the 12th SCK period.
    assign done     = tick && sck_q && (bit_q == LAST_BIT);
    assign sck      = sck_q;
    assign sdi      = sdi_q;
    assign data_out = rx_q;

    always_comb begin
        active_d = active_q;
        div_d    = div_q;
        sck_d    = sck_q;
        sdi_d    = sdi_q;
        bit_d    = bit_q;
        tx_d     = tx_q;
        rx_d     = rx_q;
        if (load) begin
            active_d = 1'b1;
            div_d    = '0;
            sck_d    = 1'b0;
            bit_d    = '0;
            sdi_d    = frame_in[FRAME_BITS-1];
            tx_d     = frame_in[FRAME_BITS-2:0];
        end else if (active_q) begin
            if (!tick) begin
                div_d = div_q + DW'(1);
            end else begin
                div_d = '0;
                sck_d = ~sck_q;
                if (!sck_q) begin
                    rx_d = {rx_q[RESULT_BITS-2:0], sdo};
                end else if (bit_q == LAST_BIT) begin
                    active_d = 1'b0;
                    sdi_d    = 1'b0;
                end else begin
                    bit_d = bit_q + 4'd1;
                    sdi_d = tx_q[FRAME_BITS-2];
                    tx_d  = {tx_q[FRAME_BITS-3:0], 1'b0};
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            active_q <= 1'b0;
            div_q    <= '0;
            sck_q    <= 1'b0;
            sdi_q    <= 1'b0;
            bit_q    <= '0;
            tx_q     <= '0;
            rx_q     <= '0;
        end else begin
            active_q <= active_d;
            div_q    <= div_d;
            sck_q    <= sck_d;
            sdi_q    <= sdi_d;
            bit_q    <= bit_d;
            tx_q     <= tx_d;
            rx_q     <= rx_d;
        end
    end

endmodule

// File: rtl/ltc2308_adc_master.sv
// rtl/ltc2308_adc_master.sv - LTC2308 conversion sequencer: CONVST pulse, tCONV wait, 12-bit SPI exchange
module ltc2308_adc_master
    import ltc2308_pkg::*;
#(
    parameter int CLK_DIV       = 2,
    parameter int CONVST_CYCLES = 2,
    parameter int CONV_CYCLES   = 80
) (
    input  logic                 clk,
    input  logic                 reset_n,
    ltc2308_adc_master_if.slave  host,
    output logic                 ADC_CONVST,
    output logic                 ADC_SCK,
    output logic                 ADC_SDI,
    input  logic                 ADC_SDO
);

    localparam int            WAIT_MAX   = (CONVST_CYCLES > CONV_CYCLES) ? CONVST_CYCLES : CONV_CYCLES;
    localparam int            CW         = $clog2(WAIT_MAX + 1);
    localparam logic [CW-1:0] PULSE_LAST = CW'(CONVST_CYCLES - 1);
    localparam logic [CW-1:0] CONV_LAST  = CW'(CONV_CYCLES - 1);

    state_e                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [FRAME_BITS-1:0]  frame_q, frame_d;
    logic [2:0]             ch_q, ch_d;
    logic [2:0]             prev_ch_q, prev_ch_d;
    logic                   primed_q, primed_d;
    logic                   valid_q, valid_d;
    logic [RESULT_BITS-1:0] data_q, data_d;
    logic [2:0]             dch_q, dch_d;
    logic                   convst_q, convst_d;
    logic                   load;
    logic                   done;
    logic [RESULT_BITS-1:0] shift_data;

    assign host.busy         = (state_q != ST_IDLE);
    assign host.valid        = valid_q;
    assign host.data         = data_q;
    assign host.data_channel = dch_q;
    assign ADC_CONVST        = convst_q;

    ltc2308_shifter #(
        .CLK_DIV (CLK_DIV)
    ) u_shifter (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (load),
        .frame_in (frame_q),
        .sdo      (ADC_SDO),
        .sck      (ADC_SCK),
        .sdi      (ADC_SDI),
        .done     (done),
        .data_out (shift_data)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        frame_d   = frame_q;
        ch_d      = ch_q;
        prev_ch_d = prev_ch_q;
        primed_d  = primed_q;
        valid_d   = 1'b0;
        data_d    = data_q;
        dch_d     = dch_q;
        convst_d  = convst_q;
        load      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (host.start) begin
                    ch_d     = host.channel;
                    frame_d  = build_frame(host.channel, host.uni);
                    cnt_d    = '0;
                    convst_d = 1'b1;
                    state_d  = ST_PULSE;
                end
            end
            ST_PULSE: begin
                if (cnt_q == PULSE_LAST) begin
                    cnt_d    = '0;
                    convst_d = 1'b0;
                    state_d  = ST_WAIT;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_WAIT: begin
                // load lands on the same edge as SHIFT entry so bit 11 appears with the state.
                if (cnt_q == CONV_LAST) begin
                    cnt_d   = '0;
                    load    = 1'b1;
                    state_d = ST_SHIFT;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_SHIFT: begin
                if (done) begin
                    state_d   = ST_IDLE;
                    prev_ch_d = ch_q;
                    primed_d  = 1'b1;
                    // The ADC returns the conversion configured by the previous frame.
                    if (primed_q) begin
                        valid_d = 1'b1;
                        data_d  = shift_data;
                        dch_d   = prev_ch_q;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            frame_q   <= '0;
            ch_q      <= '0;
            prev_ch_q <= '0;
            primed_q  <= 1'b0;
            valid_q   <= 1'b0;
            data_q    <= '0;
            dch_q     <= '0;
            convst_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            frame_q   <= frame_d;
            ch_q      <= ch_d;
            prev_ch_q <= prev_ch_d;
            primed_q  <= primed_d;
            valid_q   <= valid_d;
            data_q    <= data_d;
            dch_q     <= dch_d;
            convst_q  <= convst_d;
        end
    end

endmodule
